// File: rtl/dispatch_stage_pkg.sv
// rtl/dispatch_stage_pkg.sv - inst_name codes, tag constants and RV32I decoder
// Purpose: shared definitions for the dispatch stage. The decoder is a pure
// function so the stage can decode its queue head combinationally.
package dispatch_stage_pkg;

  localparam int DEF_TAG_W = 5;
  localparam int NO_DEP    = 0;   // tag value meaning "operand has no producer"

  // LB..SW must stay contiguous: the LSB routing test is a range check.
  typedef enum logic [5:0] {
    I_NOP = 6'd0, I_LUI, I_AUIPC, I_JAL, I_JALR,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND
  } inst_name_t;

  typedef struct packed {
    inst_name_t  name;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        is_jump;
    logic        is_store;
  } dec_t;

  // Unused source fields are forced to x0 so they never create a dependency.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [2:0] f3;
    logic       alt;
    d   = '0;
    f3  = inst[14:12];
    alt = inst[30];
    d.rd  = inst[11:7];
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    case (inst[6:0])
      7'b0110111, 7'b0010111: begin
        d.name = (inst[5]) ? I_LUI : I_AUIPC;
        d.rs1 = '0; d.rs2 = '0;
        d.imm = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        d.name = I_JAL; d.rs1 = '0; d.rs2 = '0; d.is_jump = 1'b1;
        d.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b1100111: begin
        d.name = I_JALR; d.rs2 = '0; d.is_jump = 1'b1;
        d.imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'b1100011: begin
        d.rd = '0; d.is_jump = 1'b1;
        d.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        case (f3)
          3'b000:  d.name = I_BEQ;
          3'b001:  d.name = I_BNE;
          3'b100:  d.name = I_BLT;
          3'b101:  d.name = I_BGE;
          3'b110:  d.name = I_BLTU;
          3'b111:  d.name = I_BGEU;
          default: d.name = I_NOP;
        endcase
      end
      7'b0000011: begin
        d.rs2 = '0;
        d.imm = {{20{inst[31]}}, inst[31:20]};
        case (f3)
          3'b000:  d.name = I_LB;
          3'b001:  d.name = I_LH;
          3'b010:  d.name = I_LW;
          3'b100:  d.name = I_LBU;
          3'b101:  d.name = I_LHU;
          default: d.name = I_NOP;
        endcase
      end
      7'b0100011: begin
        d.rd = '0; d.is_store = 1'b1;
        d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        case (f3)
          3'b000:  d.name = I_SB;
          3'b001:  d.name = I_SH;
          3'b010:  d.name = I_SW;
          default: d.name = I_NOP;
        endcase
      end
      7'b0010011: begin
        d.rs2 = '0;
        d.imm = {{20{inst[31]}}, inst[31:20]};
        case (f3)
          3'b000:  d.name = I_ADDI;
          3'b010:  d.name = I_SLTI;
          3'b011:  d.name = I_SLTIU;
          3'b100:  d.name = I_XORI;
          3'b110:  d.name = I_ORI;
          3'b111:  d.name = I_ANDI;
          3'b001:  begin d.name = I_SLLI; d.imm = {27'b0, inst[24:20]}; end
          default: begin d.name = alt ? I_SRAI : I_SRLI; d.imm = {27'b0, inst[24:20]}; end
        endcase
      end
      7'b0110011: begin
        case (f3)
          3'b000:  d.name = alt ? I_SUB : I_ADD;
          3'b001:  d.name = I_SLL;
          3'b010:  d.name = I_SLT;
          3'b011:  d.name = I_SLTU;
          3'b100:  d.name = I_XOR;
          3'b101:  d.name = alt ? I_SRA : I_SRL;
          3'b110:  d.name = I_OR;
          default: d.name = I_AND;
        endcase
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic is_lsb(input inst_name_t n);
    return (n >= I_LB) && (n <= I_SW);
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// rtl/dispatch_fifo.sv - instruction queue between fetcher and dispatch
// Purpose: DEPTH-entry FIFO of {inst, pc, rollback_pc, predicted_jump}.
// Ports: en_in freezes all state; flush_in empties the queue and drops a
// same-cycle push; push_in/pop_in are ignored when full/empty; head_* shows
// the oldest entry; full/empty derive from the registered count.
module dispatch_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            en_in,
  input  logic            flush_in,
  input  logic            push_in,
  input  logic [XLEN-1:0] push_inst,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_rollback_pc,
  input  logic            push_predicted_jump,
  input  logic            pop_in,
  output logic [XLEN-1:0] head_inst,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_rollback_pc,
  output logic            head_predicted_jump,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 * XLEN + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = en_in && !flush_in && push_in && !full;
  assign do_pop  = en_in && !flush_in && pop_in && !empty;

  assign {head_inst, head_pc, head_rollback_pc, head_predicted_jump} = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= {push_inst, push_pc, push_rollback_pc, push_predicted_jump};
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en_in) begin
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
        else if (!do_push && do_pop) count <= count - (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// rtl/dispatch_stage.sv - queued decode/rename/dispatch stage feeding RoB, RS, LSB, RegFile
// Purpose: buffers fetched instructions, decodes and renames the head, resolves
// operands from regfile/CDB/RoB and dispatches when the RoB and target unit have room.
// Ports: fetcher push handshake; regfile rename query (rs*_to_reg / Q*,V*_from_reg);
// RoB operand query (Q*_to_rob / Q*_ready, data*_from_rob); full flags; CDB_PORTS
// flattened write-back channels; registered dispatch bundle with one-cycle en_* pulses.
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int DEPTH     = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      valid_from_fetcher,
  output logic                      ready_to_fetcher,
  input  logic [XLEN-1:0]           inst_from_fetcher,
  input  logic [XLEN-1:0]           pc_from_fetcher,
  input  logic [XLEN-1:0]           rollback_pc_from_fetcher,
  input  logic                      predicted_jump_from_fetcher,
  output logic [4:0]                rs1_to_reg,
  output logic [4:0]                rs2_to_reg,
  input  logic [TAG_W-1:0]          Q1_from_reg,
  input  logic [TAG_W-1:0]          Q2_from_reg,
  input  logic [XLEN-1:0]           V1_from_reg,
  input  logic [XLEN-1:0]           V2_from_reg,
  output logic [TAG_W-1:0]          Q1_to_rob,
  output logic [TAG_W-1:0]          Q2_to_rob,
  input  logic                      Q1_ready_from_rob,
  input  logic                      Q2_ready_from_rob,
  input  logic [XLEN-1:0]           data1_from_rob,
  input  logic [XLEN-1:0]           data2_from_rob,
  input  logic                      rob_full_in,
  input  logic                      rs_full_in,
  input  logic                      lsb_full_in,
  input  logic                      rollback_flag_from_rob,
  input  logic [CDB_PORTS-1:0]      cdb_valid_in,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag_in,
  input  logic [CDB_PORTS*XLEN-1:0] cdb_data_in,
  output logic                      en_signal_to_rob,
  output logic                      en_signal_to_rs,
  output logic                      en_signal_to_lsb,
  output logic                      en_signal_to_reg,
  output logic [TAG_W-1:0]          tag_out,
  output logic [4:0]                rd_out,
  output logic                      is_jump_to_rob,
  output logic                      is_store_to_rob,
  output logic                      predicted_jump_to_rob,
  output logic [XLEN-1:0]           pc_out,
  output logic [XLEN-1:0]           rollback_pc_to_rob,
  output logic [5:0]                inst_name_out,
  output logic [TAG_W-1:0]          Q1_out,
  output logic [TAG_W-1:0]          Q2_out,
  output logic [XLEN-1:0]           V1_out,
  output logic [XLEN-1:0]           V2_out,
  output logic [XLEN-1:0]           imm_out
);
  logic [XLEN-1:0]  head_inst, head_pc, head_rpc;
  logic             head_pj, q_full, q_empty;
  dec_t             dec;
  logic             to_lsb, fire;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] byp_q [2];
  logic [TAG_W-1:0] res_q [2];
  logic [XLEN-1:0]  res_v [2];

  dispatch_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .en_in               (rdy_in),
    .flush_in            (rollback_flag_from_rob),
    .push_in             (valid_from_fetcher),
    .push_inst           (inst_from_fetcher),
    .push_pc             (pc_from_fetcher),
    .push_rollback_pc    (rollback_pc_from_fetcher),
    .push_predicted_jump (predicted_jump_from_fetcher),
    .pop_in              (fire),
    .head_inst           (head_inst),
    .head_pc             (head_pc),
    .head_rollback_pc    (head_rpc),
    .head_predicted_jump (head_pj),
    .full                (q_full),
    .empty               (q_empty)
  );

  assign ready_to_fetcher = !q_full;
  assign dec        = decode(head_inst[31:0]);
  assign rs1_to_reg = dec.rs1;
  assign rs2_to_reg = dec.rs2;
  assign Q1_to_rob  = byp_q[0];
  assign Q2_to_rob  = byp_q[1];
  assign to_lsb     = is_lsb(dec.name);
  assign fire       = !q_empty && !rob_full_in && !(to_lsb ? lsb_full_in : rs_full_in)
                      && !rollback_flag_from_rob;

  // Operand resolution. The registered dispatch bundle still describes the
  // instruction dispatched last cycle, whose rename the regfile has not yet
  // absorbed, so it overrides the regfile tag for a matching source.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0]       rs;
      logic [TAG_W-1:0] q_reg;
      logic [XLEN-1:0]  v_reg, v_rob;
      logic             rob_rdy, hit;
      rs      = (i == 0) ? dec.rs1 : dec.rs2;
      q_reg   = (i == 0) ? Q1_from_reg : Q2_from_reg;
      v_reg   = (i == 0) ? V1_from_reg : V2_from_reg;
      rob_rdy = (i == 0) ? Q1_ready_from_rob : Q2_ready_from_rob;
      v_rob   = (i == 0) ? data1_from_rob : data2_from_rob;
      hit      = 1'b0;
      byp_q[i] = TAG_W'(NO_DEP);
      res_q[i] = TAG_W'(NO_DEP);
      res_v[i] = '0;
      if (rs != 5'd0) begin
        byp_q[i] = (en_signal_to_reg && rd_out == rs) ? tag_out : q_reg;
        if (byp_q[i] == TAG_W'(NO_DEP)) begin
          res_v[i] = v_reg;
        end else begin
          for (int c = 0; c < CDB_PORTS; c++) begin
            if (!hit && cdb_valid_in[c] && cdb_tag_in[c*TAG_W +: TAG_W] == byp_q[i]) begin
              hit      = 1'b1;
              res_v[i] = cdb_data_in[c*XLEN +: XLEN];
            end
          end
          if (hit) begin
            res_q[i] = TAG_W'(NO_DEP);
          end else if (rob_rdy) begin
            res_v[i] = v_rob;
          end else begin
            res_q[i] = byp_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_cnt               <= TAG_W'(1);
      en_signal_to_rob      <= 1'b0;
      en_signal_to_rs       <= 1'b0;
      en_signal_to_lsb      <= 1'b0;
      en_signal_to_reg      <= 1'b0;
      tag_out               <= '0;
      rd_out                <= '0;
      is_jump_to_rob        <= 1'b0;
      is_store_to_rob       <= 1'b0;
      predicted_jump_to_rob <= 1'b0;
      pc_out                <= '0;
      rollback_pc_to_rob    <= '0;
      inst_name_out         <= '0;
      Q1_out                <= '0;
      Q2_out                <= '0;
      V1_out                <= '0;
      V2_out                <= '0;
      imm_out               <= '0;
    end else if (rdy_in) begin
      // fire is already false during rollback, which also clears the pulses.
      en_signal_to_rob <= fire;
      en_signal_to_reg <= fire;
      en_signal_to_rs  <= fire && !to_lsb;
      en_signal_to_lsb <= fire && to_lsb;
      if (rollback_flag_from_rob) begin
        tag_cnt <= TAG_W'(1);
      end else if (fire) begin
        tag_cnt               <= (tag_cnt == '1) ? TAG_W'(1) : tag_cnt + TAG_W'(1);
        tag_out               <= tag_cnt;
        rd_out                <= dec.rd;
        is_jump_to_rob        <= dec.is_jump;
        is_store_to_rob       <= dec.is_store;
        predicted_jump_to_rob <= head_pj;
        pc_out                <= head_pc;
        rollback_pc_to_rob    <= head_rpc;
        inst_name_out         <= dec.name;
        Q1_out                <= res_q[0];
        Q2_out                <= res_q[1];
        V1_out                <= res_v[0];
        V2_out                <= res_v[1];
        imm_out               <= XLEN'(dec.imm);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb/tb_dispatch_stage.sv - directed scoreboard bench for dispatch_stage
module tb_dispatch_stage;
  localparam int XLEN = 32, TAG_W = 5, DEPTH = 4, CDB_PORTS = 2;
  localparam logic [5:0]  N_LW = 6'd13, N_ADDI = 6'd19, N_ADD = 6'd28;
  localparam logic [31:0] ADDI_X1_5 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADD_X2    = 32'h00108133;  // add  x2,x1,x1
  localparam logic [31:0] LW_X3     = 32'h00022183;  // lw   x3,0(x4)
  localparam logic [31:0] ADDI_X5   = 32'h00130293;  // addi x5,x6,1

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic [5:0]  name;
    logic [4:0]  q1;
    logic [31:0] v1;
    logic [4:0]  q2;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        lsb;
  } exp_t;

  logic clk_in, rst_n_in, rdy_in;
  logic valid_from_fetcher, ready_to_fetcher, predicted_jump_from_fetcher;
  logic [XLEN-1:0] inst_from_fetcher, pc_from_fetcher, rollback_pc_from_fetcher;
  logic [4:0] rs1_to_reg, rs2_to_reg, rd_out;
  logic [TAG_W-1:0] Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob, tag_out, Q1_out, Q2_out;
  logic [XLEN-1:0] V1_from_reg, V2_from_reg, data1_from_rob, data2_from_rob;
  logic Q1_ready_from_rob, Q2_ready_from_rob, rob_full_in, rs_full_in, lsb_full_in;
  logic rollback_flag_from_rob;
  logic [CDB_PORTS-1:0] cdb_valid_in;
  logic [CDB_PORTS*TAG_W-1:0] cdb_tag_in;
  logic [CDB_PORTS*XLEN-1:0] cdb_data_in;
  logic en_signal_to_rob, en_signal_to_rs, en_signal_to_lsb, en_signal_to_reg;
  logic is_jump_to_rob, is_store_to_rob, predicted_jump_to_rob;
  logic [XLEN-1:0] pc_out, rollback_pc_to_rob, V1_out, V2_out, imm_out;
  logic [5:0] inst_name_out;

  dispatch_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .valid_from_fetcher(valid_from_fetcher), .ready_to_fetcher(ready_to_fetcher),
    .inst_from_fetcher(inst_from_fetcher), .pc_from_fetcher(pc_from_fetcher),
    .rollback_pc_from_fetcher(rollback_pc_from_fetcher),
    .predicted_jump_from_fetcher(predicted_jump_from_fetcher),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
    .data1_from_rob(data1_from_rob), .data2_from_rob(data2_from_rob),
    .rob_full_in(rob_full_in), .rs_full_in(rs_full_in), .lsb_full_in(lsb_full_in),
    .rollback_flag_from_rob(rollback_flag_from_rob),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .en_signal_to_rob(en_signal_to_rob), .en_signal_to_rs(en_signal_to_rs),
    .en_signal_to_lsb(en_signal_to_lsb), .en_signal_to_reg(en_signal_to_reg),
    .tag_out(tag_out), .rd_out(rd_out), .is_jump_to_rob(is_jump_to_rob),
    .is_store_to_rob(is_store_to_rob), .predicted_jump_to_rob(predicted_jump_to_rob),
    .pc_out(pc_out), .rollback_pc_to_rob(rollback_pc_to_rob), .inst_name_out(inst_name_out),
    .Q1_out(Q1_out), .Q2_out(Q2_out), .V1_out(V1_out), .V2_out(V2_out), .imm_out(imm_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic sb_on = 1'b1;
  logic [4:0] last_tag = '0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] tag, input logic [4:0] rd, input logic [5:0] name,
                              input logic [4:0] q1, input logic [31:0] v1, input logic [4:0] q2,
                              input logic [31:0] v2, input logic [31:0] imm, input logic [31:0] pc,
                              input logic lsb);
    exp_t e;
    e.tag = tag; e.rd = rd; e.name = name; e.q1 = q1; e.v1 = v1;
    e.q2 = q2; e.v2 = v2; e.imm = imm; e.pc = pc; e.lsb = lsb;
    return e;
  endfunction

  // One clock; outputs sampled 1 time unit after the edge, each dispatch popped from the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (sb_on && en_signal_to_rob === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_fire", {63'd0, en_signal_to_rob}, 64'd0);
      end else begin
        e = sb.pop_front();
        last_tag = e.tag;
        chk("tag_out", tag_out, e.tag);
        chk("rd_out", rd_out, e.rd);
        chk("inst_name", inst_name_out, e.name);
        chk("Q1_out", Q1_out, e.q1);
        chk("V1_out", V1_out, e.v1);
        chk("Q2_out", Q2_out, e.q2);
        chk("V2_out", V2_out, e.v2);
        chk("imm_out", imm_out, e.imm);
        chk("pc_out", pc_out, e.pc);
        chk("rollback_pc", rollback_pc_to_rob, e.pc + 32'h100);
        chk("pred_jump", predicted_jump_to_rob, e.pc[2]);
        chk("en_reg", en_signal_to_reg, 1'b1);
        chk("en_rs", en_signal_to_rs, !e.lsb);
        chk("en_lsb", en_signal_to_lsb, e.lsb);
      end
    end
  endtask

  task automatic drive_push(input logic [31:0] inst, input logic [31:0] pc);
    valid_from_fetcher = 1'b1;
    inst_from_fetcher = inst;
    pc_from_fetcher = pc;
    rollback_pc_from_fetcher = pc + 32'h100;
    predicted_jump_from_fetcher = pc[2];
    tick();
    valid_from_fetcher = 1'b0;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    sb.push_back(e);
    drive_push(inst, pc);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1;
    valid_from_fetcher = 1'b0; inst_from_fetcher = '0; pc_from_fetcher = '0;
    rollback_pc_from_fetcher = '0; predicted_jump_from_fetcher = 1'b0;
    Q1_from_reg = '0; Q2_from_reg = '0; V1_from_reg = '0; V2_from_reg = '0;
    Q1_ready_from_rob = 1'b0; Q2_ready_from_rob = 1'b0; data1_from_rob = '0; data2_from_rob = '0;
    rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0; rollback_flag_from_rob = 1'b0;
    cdb_valid_in = '0; cdb_tag_in = '0; cdb_data_in = '0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_en_rob", en_signal_to_rob, 1'b0);
    chk("rst_en_rs", en_signal_to_rs, 1'b0);
    chk("rst_en_lsb", en_signal_to_lsb, 1'b0);
    chk("rst_en_reg", en_signal_to_reg, 1'b0);
    chk("rst_ready", ready_to_fetcher, 1'b1);
    chk("rst_tag_out", tag_out, 5'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    #2 rst_n_in = 1'b1;

    // addi x1,x0,5: fires on the edge after the push
    push(ADDI_X1_5, 32'h0, mk(5'd1, 5'd1, N_ADDI, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5, 32'h0, 1'b0));
    chk("push_edge_no_fire", en_signal_to_rob, 1'b0);
    tick();
    chk("first_fire", en_signal_to_rob, 1'b1);
    drain(5);

    // Rollback on an idle queue restarts tags; then dependent pair with stale regfile
    rollback_flag_from_rob = 1'b1;
    tick();
    rollback_flag_from_rob = 1'b0;
    chk("rollback_clears_en", en_signal_to_rob, 1'b0);
    push(ADDI_X1_5, 32'h10, mk(5'd1, 5'd1, N_ADDI, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5, 32'h10, 1'b0));
    push(ADD_X2, 32'h14, mk(5'd2, 5'd2, N_ADD, 5'd1, 32'd0, 5'd1, 32'd0, 32'd0, 32'h14, 1'b0));
    chk("b2b_first", en_signal_to_rob, 1'b1);
    tick();
    chk("b2b_no_bubble", en_signal_to_rob, 1'b1);
    drain(5);

    // lw held by a full LSB for 3 cycles, RS has room
    V1_from_reg = 32'h1000; V2_from_reg = 32'h2222; lsb_full_in = 1'b1;
    push(LW_X3, 32'h20, mk(5'd3, 5'd3, N_LW, 5'd0, 32'h1000, 5'd0, 32'd0, 32'd0, 32'h20, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lsb_full_hold", en_signal_to_rob, 1'b0);
    end
    lsb_full_in = 1'b0;
    tick();
    chk("lsb_release_fire", en_signal_to_lsb, 1'b1);
    drain(5);

    // Head stalled on Q1=7: CDB ch1, both channels, RoB-ready, still pending
    Q1_from_reg = 5'd7; V1_from_reg = 32'h5555;
    for (int k = 0; k < 4; k++) begin
      logic [4:0]  q1e;
      logic [31:0] v1e;
      q1e = (k == 3) ? 5'd7 : 5'd0;
      v1e = (k == 0) ? 32'hDEAD : (k == 1) ? 32'hBEEF : (k == 2) ? 32'h1234 : 32'h0;
      rob_full_in = 1'b1;
      push(ADDI_X5, 32'h40 + 32'(k * 4),
           mk(5'(4 + k), 5'd5, N_ADDI, q1e, v1e, 5'd0, 32'd0, 32'd1, 32'h40 + 32'(k * 4), 1'b0));
      tick();
      chk("stall_hold", en_signal_to_rob, 1'b0);
      cdb_tag_in = {5'd7, 5'd7};
      cdb_data_in = {32'hDEAD, 32'hBEEF};
      cdb_valid_in = (k == 0) ? 2'b10 : (k == 1) ? 2'b11 : 2'b00;
      Q1_ready_from_rob = (k == 2);
      data1_from_rob = 32'h1234;
      rob_full_in = 1'b0;
      tick();
      cdb_valid_in = '0; Q1_ready_from_rob = 1'b0;
      drain(3);
    end

    // Fill the queue, refuse a 5th push, then drain exactly four
    Q1_from_reg = '0; V1_from_reg = 32'h11; rob_full_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ready_before_fill", ready_to_fetcher, 1'b1);
      push(ADDI_X5, 32'h200 + 32'(k * 4),
           mk(5'(8 + k), 5'd5, N_ADDI, 5'd0, 32'h11, 5'd0, 32'd0, 32'd1, 32'h200 + 32'(k * 4), 1'b0));
    end
    chk("full_ready_low", ready_to_fetcher, 1'b0);
    drive_push(ADD_X2, 32'h2F0);
    chk("fifth_refused_ready", ready_to_fetcher, 1'b0);
    rob_full_in = 1'b0;
    tick();
    chk("ready_after_pop", ready_to_fetcher, 1'b1);
    drain(10);
    repeat (3) tick();

    // Rollback with a simultaneous push flushes everything
    rob_full_in = 1'b1;
    drive_push(ADDI_X5, 32'h280);
    drive_push(ADDI_X5, 32'h284);
    rollback_flag_from_rob = 1'b1;
    drive_push(ADDI_X5, 32'h288);
    rollback_flag_from_rob = 1'b0;
    chk("rollback_ready", ready_to_fetcher, 1'b1);
    chk("rollback_no_en", en_signal_to_rob, 1'b0);
    rob_full_in = 1'b0;
    repeat (3) tick();
    push(ADDI_X1_5, 32'h300, mk(5'd1, 5'd1, N_ADDI, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5, 32'h300, 1'b0));
    drain(5);

    // 31-long stream: tags 2..31 then wrap to 1; rdy_in freeze in the middle
    for (int i = 0; i < 31; i++) begin
      push(ADDI_X5, 32'h400 + 32'(i * 4),
           mk((i < 30) ? 5'(i + 2) : 5'd1, 5'd5, N_ADDI, 5'd0, 32'h11, 5'd0, 32'd0, 32'd1,
              32'h400 + 32'(i * 4), 1'b0));
      if (i == 15) begin
        sb_on = 1'b0;
        rdy_in = 1'b0;
        repeat (3) begin
          tick();
          chk("freeze_en_rob", en_signal_to_rob, 1'b1);
          chk("freeze_tag_out", tag_out, last_tag);
        end
        rdy_in = 1'b1;
        sb_on = 1'b1;
      end
    end
    drain(10);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

Parametrised successor of the single-issue dispatcher. It sits between the fetcher and the RoB, RS, LSB and RegFile. A DEPTH-entry instruction queue with valid/ready backpressure absorbs the fetcher's output. The head entry is decoded, renamed and forwarded from CDB_PORTS write-back channels, then dispatched only when the destination unit and the RoB have room. The stage self-allocates RoB tags, bypasses its own last rename, and flushes completely on rollback.

## Interface
- XLEN, 32, data width
- TAG_W, 5, RoB tag width; tag 0 means "no dependency", live tags are 1..2^TAG_W-1
- DEPTH, 4, instruction queue entries (power of 2, ≥2)
- CDB_PORTS, 2, write-back broadcast channels (ALU, LSU, ...)
- clk_in  in  1  clock, rising edge
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global enable; low freezes all state and outputs
- valid_from_fetcher / ready_to_fetcher  in/out  1  push handshake
- inst_from_fetcher, pc_from_fetcher, rollback_pc_from_fetcher  in  XLEN  pushed payload
- predicted_jump_from_fetcher  in  1  pushed payload
- rs1_to_reg, rs2_to_reg  out  5  head source registers (combinational)
- Q1_from_reg, Q2_from_reg  in  TAG_W  rename tags
- V1_from_reg, V2_from_reg  in  XLEN  register values
- Q1_to_rob, Q2_to_rob  out  TAG_W  = Q*_from_reg after own-rename bypass
- Q1_ready_from_rob, Q2_ready_from_rob  in  1  tag already has a result
- data1_from_rob, data2_from_rob  in  XLEN  that result
- rob_full_in, rs_full_in, lsb_full_in  in  1  no room, counting any entry already pulsed in
- rollback_flag_from_rob  in  1  flush
- cdb_valid_in  in  CDB_PORTS  per-channel valid
- cdb_tag_in  in  CDB_PORTS*TAG_W  flattened tags, channel 0 in the LSBs
- cdb_data_in  in  CDB_PORTS*XLEN  flattened results
- en_signal_to_rob, en_signal_to_rs, en_signal_to_lsb, en_signal_to_reg  out  1  dispatch pulses
- tag_out  out  TAG_W  allocated RoB tag, to all consumers
- rd_out  out  5  to RoB and RegFile
- is_jump_to_rob, is_store_to_rob, predicted_jump_to_rob  out  1
- pc_out, rollback_pc_to_rob  out  XLEN
- inst_name_out  out  6  to RS or LSB
- Q1_out, Q2_out  out  TAG_W  resolved tags, 0 when the value is present
- V1_out, V2_out, imm_out  out  XLEN

## Operation
- **Queue:** push when valid_from_fetcher && ready_to_fetcher. ready_to_fetcher = !full (registered count). Push and pop in the same cycle leaves the count unchanged.
- **Decode:** the head is decoded combinationally. Its target is LSB if inst_name is in `LB..`SW`, otherwise RS.
- **Fire condition:** head valid && !rob_full_in && !(target full) && !rollback_flag_from_rob. On fire, pop the head and register all outputs. Pulse en_signal_to_rob, en_signal_to_reg and exactly one of en_signal_to_rs/en_signal_to_lsb, each high for one cycle.
- **Operand resolution, first hit wins:**
  - If rs == 0: Q=0, V=0.
  - Own-rename bypass: if en_signal_to_reg && rd_out == rs && rd_out != 0, then Q = tag_out.
  - Otherwise Q = Q*_from_reg.
  - If Q == 0: V = V*_from_reg.
  - Else, lowest-index CDB channel with a matching valid tag: Q=0, V = that channel's data.
  - Else, if RoB ready: Q=0, V = data*_from_rob.
  - Else: keep Q, V = 0.
- **Tag counter:** reset and rollback load 1. It increments on each fire and wraps 2^TAG_W-1 → 1. The RoB follows the same allocation rule.
- **Rollback:** takes priority over all other activity. Queue emptied, same-cycle push dropped, all en_* cleared, counter = 1, bypass invalidated.
- **rdy_in low:** nothing changes, including the en_* levels.

## Timing
- Reset: every en_* = 0, queue empty, ready_to_fetcher = 1, tag_out = 0, all other outputs 0.
- Push at edge t → earliest fire at edge t+1 → outputs valid during cycle t+1..t+2.
- Throughput: one instruction per cycle. Back-to-back dependent instructions need no bubble (own-rename bypass).
- Stall: the head re-evaluates operands every cycle, so a CDB broadcast during the stall is captured.
- Full queue: ready_to_fetcher drops the cycle after the DEPTH-th push and rises the cycle after a pop.

## Structure
- Shared package/defines: inst_name codes (`LB`…`SW`), tag width, NO_DEP = 0.
- Reuse the existing decoder module.
- Sub-module dispatch_fifo: DEPTH × {inst, pc, rollback_pc, predicted_jump}, with flush.

## Test plan
- Reset, then push `addi x1,x0,5` at pc 0x0 → fire next edge: en_rob/en_rs/en_reg = 1, tag_out = 1, Q1 = 0, V1 = 0, imm = 5.
- `addi x1` then `add x2,x1,x1` back-to-back with a stale regfile → second instruction has Q1 = Q2 = 1, tag_out = 2, no bubble.
- `lw x3,0(x4)` with rs_full_in = 0 and lsb_full_in = 1 for 3 cycles → held; fires on the first cycle after lsb_full_in drops; only en_lsb pulses.
- Head stalled with Q1 = 7, then cdb_valid_in[1] with tag 7 and data 0xDEAD → dispatched Q1 = 0, V1 = 0xDEAD. Both channels matching → channel 0 wins.
- Push 4 with no fire → ready_to_fetcher = 0; a 5th valid is not accepted. Rollback with a simultaneous push → queue empty, tag restarts at 1.
- 31 fires → tag wraps 31 → 1, never 0. rdy_in low mid-stream → outputs frozen; resume produces no duplicate pops.
